comm_slave: RTL and testbench
=============================

# comm_slave

UART command receiver for the far end of the two-byte serial command link. Deserialises 8N1 frames on `RX`, pairs them high byte first and low byte second into a 16-bit command, and presents it to the command-processing logic with a sticky `cmd_rdy` flag. It contains one byte-level UART receiver sub-module plus a byte-assembly FSM.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit; must be ≥ 8.
- `TIMEOUT_CYC`, default 32'd5_000_000: maximum gap, in clocks, between the high byte and the low byte. Used only with `CMD_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RX`  in  1  serial line, idle high, asynchronous to `clk`.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy`.
- `cmd`  out  16  last complete command; resets to 16'h0000.
- `cmd_rdy`  out  1  a new command is valid; resets to 0.
- `frm_err`  out  1  one-cycle pulse on a bad stop bit; resets to 0.

## Operation
- `RX` passes through a 2-flop synchroniser. Both flops reset to 1 (line idle).
- Receiver states are IDLE, RECV.
  - IDLE → RECV on a synchronised falling edge at cycle t0.
  - In RECV, samples are taken at t0 + BAUD_DIV/2 + k·BAUD_DIV for k = 0..9. BAUD_DIV/2 uses integer division.
  - k=0 is the start bit. If it samples high, this is a false start: return to IDLE with no output.
  - k=1..8 are data bits, LSB first, shifted right into an 8-bit register.
  - k=9 is the stop bit. If it is 1, `rx_rdy` pulses for one cycle with `rx_data` valid. If it is 0, `frm_err` pulses instead, the byte is discarded and the assembly FSM is unaffected.
  - RECV → IDLE on the cycle after the stop sample. A back-to-back start edge is accepted immediately.
- Assembly FSM states are WAIT_HI, WAIT_LO.
  - WAIT_HI, `rx_rdy`: latch `rx_data` into `hi_byte`, clear `cmd_rdy`, go to WAIT_LO.
  - WAIT_LO, `rx_rdy`: `cmd` ← {`hi_byte`, `rx_data`}, set `cmd_rdy`, go to WAIT_HI.
- `cmd_rdy` is sticky until `clr_cmd_rdy` or the next high byte arrives.
  - If a set and `clr_cmd_rdy` occur in the same cycle, the set wins.
  - If a clear from a new high byte and `clr_cmd_rdy` occur in the same cycle, the result is 0.
- `cmd` changes only when a command completes. It holds its value through partial commands, timeouts and framing errors.
- Async reset at any point, including mid-frame or in WAIT_LO, returns both FSMs to idle, clears all outputs, and discards any partial byte or high byte.

## Timing
- Pin to synchronised edge takes 2–3 clocks.
- `rx_rdy` and `frm_err` assert at t0 + BAUD_DIV/2 + 9·BAUD_DIV + 1.
- `cmd_rdy` and the new `cmd` are registered 1 clock after the low byte's `rx_rdy`. Both become visible together.
- `clr_cmd_rdy` takes effect on the next edge, so `cmd_rdy` is low the following cycle.
- There is no back-pressure. A command that completes while `cmd_rdy` = 1 overwrites `cmd`.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT_LO and increments each cycle in WAIT_LO.
  - When it reaches `TIMEOUT_CYC` without a valid low byte, the FSM discards `hi_byte` and returns to WAIT_HI. `cmd` and `cmd_rdy` are untouched.
  - If `rx_rdy` arrives in the same cycle as the timeout, `rx_rdy` wins and the command completes.
- `CMD_TIMEOUT_EN` undefined: there is no counter, and WAIT_LO waits indefinitely.

## Structure
- Package `comm_pkg` holds:
  - `rx_state_t` {IDLE, RECV};
  - `asm_state_t` {WAIT_HI, WAIT_LO};
  - default constants `BAUD_DIV_DEF` and `TIMEOUT_CYC_DEF`.
- Sub-module `uart_rx` contains the synchroniser, baud counter, bit counter and shift register.
  - Ports: `clk`, `rst_n`, `RX`, `rx_data[7:0]`, `rx_rdy`, `frm_err`.
- `comm_slave` contains the assembly FSM, `hi_byte`, `cmd`, `cmd_rdy` and the optional timeout counter.

## Test plan
All scenarios use BAUD_DIV = 16, TIMEOUT_CYC = 400 and `CMD_TIMEOUT_EN` defined unless stated.
- Send bytes A5 then 3C back-to-back → `cmd` = 16'hA53C and `cmd_rdy` = 1 exactly 1 clock after the second `rx_rdy`. `cmd_rdy` stays 1 until `clr_cmd_rdy` pulses, then is 0 the next cycle.
- Send 12, 34, then 56 with `cmd_rdy` still set → `cmd_rdy` drops when 56 arrives. Send 78 → `cmd` = 16'h5678.
- Send 12 with stop bit 0 → `frm_err` pulses once, no state change. Send FF, 00 → `cmd` = 16'hFF00.
- Send 80, idle for 500 clocks, then send 11, 22 → the timeout discards 80 and `cmd` = 16'h1122. Build without the macro → `cmd` = 16'h8011.
- Apply a 4-clock low glitch on `RX` → start sample high, no `rx_rdy`, no `frm_err`.
- Assert `rst_n` low halfway through the low byte of BE, EF → `cmd` = 0, `cmd_rdy` = 0. The next full command 0102 decodes correctly.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared types and default constants for the two-byte serial command receiver.
package comm_pkg;

  typedef enum logic {
    IDLE,
    RECV
  } rx_state_t;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } asm_state_t;

  localparam int unsigned BAUD_DIV_DEF    = 2604;
  localparam logic [31:0] TIMEOUT_CYC_DEF = 32'd5_000_000;

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: RX synchroniser, mid-bit sampling baud timer, bit counter
// and LSB-first shift register. Pulses rx_rdy on a good stop bit, frm_err on a bad one.
//
// state | meaning
// IDLE  | line idle, waiting for a synchronised falling edge
// RECV  | sampling start, 8 data and stop bits at mid-bit points
module uart_rx
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);

  localparam int unsigned    CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [3:0]       STOP_BIT  = 4'd9;

  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_rdy_q, rx_rdy_d;
  logic             frm_err_q, frm_err_d;
  logic             fall;

  // rx_s3_q is the previous synchronised value, used only for edge detection.
  assign fall = rx_s3_q & ~rx_s2_q;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_rdy_d   = 1'b0;
    frm_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d    = RECV;
          baud_cnt_d = HALF_LOAD;
          bit_cnt_d  = 4'd0;
        end
      end
      RECV: begin
        if (baud_cnt_q != '0) begin
          baud_cnt_d = baud_cnt_q - CNT_ONE;
        end else begin
          baud_cnt_d = FULL_LOAD;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd0) begin
            if (rx_s2_q) state_d = IDLE;
          end else if (bit_cnt_q == STOP_BIT) begin
            state_d   = IDLE;
            rx_rdy_d  = rx_s2_q;
            frm_err_d = ~rx_s2_q;
          end else begin
            shift_d = {rx_s2_q, shift_q[7:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rx_rdy_q   <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_rdy_q   <= rx_rdy_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign rx_data = shift_q;
  assign rx_rdy  = rx_rdy_q;
  assign frm_err = frm_err_q;

endmodule

// File: rtl/comm_slave.sv
// Two-byte command receiver: pairs UART bytes high-then-low into a 16-bit cmd
// with a sticky cmd_rdy flag. Optional high/low gap timeout: CMD_TIMEOUT_EN.
//
// state   | meaning
// WAIT_HI | expecting the high byte of a command
// WAIT_LO | high byte held, expecting the low byte
module comm_slave
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = BAUD_DIV_DEF,
  parameter logic [31:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  if (BAUD_DIV < 8) begin : g_baud_chk
    $error("comm_slave: BAUD_DIV must be at least 8");
  end
  if (TIMEOUT_CYC == 32'd0) begin : g_tmo_chk
    $error("comm_slave: TIMEOUT_CYC must be non-zero");
  end

  logic [7:0]  rx_data;
  logic        rx_rdy;
  asm_state_t  state_q, state_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        tmo_hit;

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .frm_err (frm_err)
  );

`ifdef CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // Counter sits at zero outside WAIT_LO, so it reads zero on the first WAIT_LO cycle.
  always_comb begin
    tmo_cnt_d = 32'd0;
    if (state_q == WAIT_LO) tmo_cnt_d = tmo_cnt_q + 32'd1;
  end

  assign tmo_hit = (state_q == WAIT_LO) && (tmo_cnt_q == TIMEOUT_CYC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= 32'd0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Clear is applied first so that a completing command overrides it.
  always_comb begin
    state_d   = state_q;
    hi_byte_d = hi_byte_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    case (state_q)
      WAIT_HI: begin
        if (rx_rdy) begin
          hi_byte_d = rx_data;
          cmd_rdy_d = 1'b0;
          state_d   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          cmd_d     = {hi_byte_q, rx_data};
          cmd_rdy_d = 1'b1;
          state_d   = WAIT_HI;
        end else if (tmo_hit) begin
          hi_byte_d = 8'h00;
          state_d   = WAIT_HI;
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_HI;
      hi_byte_q <= 8'h00;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_byte_q <= hi_byte_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_comm_slave.sv
// Directed scoreboard bench for comm_slave at BAUD_DIV=16, TIMEOUT_CYC=400.
module tb_comm_slave;

  localparam int BD = 16;
  // Frame driven right after posedge c0: sync edge at c0+2, stop sample at
  // c0+2+8+9*16, rx_rdy visible one cycle later, cmd_rdy one more.
  localparam int RDY_LAT = 155;
  localparam int CMD_LAT = 156;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  comm_slave #(
    .BAUD_DIV    (BD),
    .TIMEOUT_CYC (32'd400)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] cmd;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_frm    = 0;
  int n_rxrdy  = 0;
  int frm_cyc  = -1;
  logic rdy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every cmd_rdy rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_prev = 1'b0;
    end else begin
      if (dut.rx_rdy) n_rxrdy++;
      if (frm_err) begin
        n_frm++;
        frm_cyc = cyc;
      end
      if (cmd_rdy && !rdy_prev) begin
        chk("sb_expected_cmd", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("cmd_value", 32'(cmd), 32'(e.cmd));
          chk("cmd_rdy_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      rdy_prev = cmd_rdy;
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Caller must be 1 time unit after a posedge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (BD) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(posedge clk);
      #1;
    end
    RX = stop;
    repeat (BD) @(posedge clk);
    #1;
    RX = 1'b1;
  endtask

  task automatic expect_cmd(input logic [15:0] c);
    exp_t e;
    e.cmd = c;
    e.cyc = cyc + CMD_LAT;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input logic [15:0] c);
    send_byte(c[15:8], 1'b1);
    expect_cmd(c);
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    align();
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int rx0, fr0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
    chk("rst_frm_err", 32'(frm_err), 32'h0);
    align();
    rst_n = 1'b1;
    repeat (4) align();

    // A5 3C back to back, sticky flag, then acknowledge.
    send_cmd(16'hA53C);
    repeat (20) align();
    @(negedge clk);
    chk("a53c_sticky", 32'(cmd_rdy), 32'h1);
    align();
    pulse_clr();
    @(negedge clk);
    chk("a53c_cleared", 32'(cmd_rdy), 32'h0);
    align();

    // 12 34, then a new high byte drops cmd_rdy; clr coincident with set.
    send_cmd(16'h1234);
    send_byte(8'h56, 1'b1);
    @(negedge clk);
    chk("hi_byte_clears_rdy", 32'(cmd_rdy), 32'h0);
    chk("cmd_held_partial", 32'(cmd), 32'h1234);
    align();
    expect_cmd(16'h5678);
    fork
      send_byte(8'h78, 1'b1);
      begin
        repeat (RDY_LAT) @(posedge clk);
        #1 clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
      end
    join
    @(negedge clk);
    chk("set_beats_clr", 32'(cmd_rdy), 32'h1);
    align();

    // Framing error leaves the assembler untouched.
    pulse_clr();
    c = cyc;
    send_byte(8'h12, 1'b0);
    @(negedge clk);
    chk("frm_err_count", 32'(n_frm), 32'd1);
    chk("frm_err_cycle", 32'(frm_cyc), 32'(c + RDY_LAT));
    chk("frm_cmd_held", 32'(cmd), 32'h5678);
    chk("frm_rdy_low", 32'(cmd_rdy), 32'h0);
    align();
    send_cmd(16'hFF00);

    // Gap longer than the timeout between high and low bytes.
    pulse_clr();
    send_byte(8'h80, 1'b1);
    repeat (500) align();
`ifdef CMD_TIMEOUT_EN
    send_cmd(16'h1122);
    @(negedge clk);
    chk("timeout_cmd", 32'(cmd), 32'h1122);
`else
    expect_cmd(16'h8011);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    @(negedge clk);
    chk("no_timeout_cmd", 32'(cmd), 32'h8011);
`endif
    align();

    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_cmd", 32'(cmd), 32'h0);
    chk("reset_cmd_rdy", 32'(cmd_rdy), 32'h0);
    align();
    rst_n = 1'b1;
    repeat (4) align();

    // Short low glitch is a false start.
    rx0 = n_rxrdy;
    fr0 = n_frm;
    RX = 1'b0;
    repeat (4) align();
    RX = 1'b1;
    repeat (200) align();
    chk("glitch_no_rx_rdy", 32'(n_rxrdy), 32'(rx0));
    chk("glitch_no_frm_err", 32'(n_frm), 32'(fr0));

    // Reset in WAIT_LO, halfway through the low byte.
    send_cmd(16'hC396);
    send_byte(8'hBE, 1'b1);
    fork
      send_byte(8'hEF, 1'b1);
      begin
        repeat (80) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midframe_rst_cmd", 32'(cmd), 32'h0);
        chk("midframe_rst_rdy", 32'(cmd_rdy), 32'h0);
      end
    join
    repeat (10) align();
    rst_n = 1'b1;
    repeat (10) align();
    chk("post_rst_cmd", 32'(cmd), 32'h0);
    chk("post_rst_rdy", 32'(cmd_rdy), 32'h0);
    send_cmd(16'h0102);
    @(negedge clk);
    chk("final_cmd", 32'(cmd), 32'h0102);
    chk("final_rdy", 32'(cmd_rdy), 32'h1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
